// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N:1 datapath multiplexer.
// Arbitration mode encodings plus a clog2 that never returns less than 1.
package mux_pkg;

   localparam int MODE_SEL = 0;
   localparam int MODE_RR  = 1;

   // Index fields stay at least one bit wide so N=1 still has a legal select port.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: grants the first requesting channel
// found when searching ptr, ptr+1, ... modulo N.
module rr_arbiter_n
   import mux_pkg::*;
#(
   parameter int  N     = 4,
   localparam int SEL_W = clog2_min1(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             gnt_valid
);

   logic [SEL_W:0]   w_sum [N];
   logic [SEL_W-1:0] w_idx [N];
   logic [N-1:0]     w_hit;

   // Offset gi from the pointer, folded back into 0..N-1; ptr is always < N.
   for (genvar gi = 0; gi < N; gi++) begin : g_rot
      assign w_sum[gi] = {1'b0, ptr} + (SEL_W+1)'(gi);
      assign w_idx[gi] = (w_sum[gi] >= (SEL_W+1)'(N))
                         ? SEL_W'(w_sum[gi] - (SEL_W+1)'(N))
                         : SEL_W'(w_sum[gi]);
      assign w_hit[gi] = req[w_idx[gi]];
   end

   // Scan from the far end so the smallest offset wins.
   always_comb begin
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_hit[k]) begin
            gnt_idx   = w_idx[k];
            gnt_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_pipe_n.sv
// Registered N:1 datapath multiplexer with valid/ready handshake, explicit-select
// or round-robin arbitration. Optional MUX_PIPE_SELERR_EN adds a sticky sel_err flag.
module mux_pipe_n
   import mux_pkg::*;
#(
   parameter int  WIDTH = 32,
   parameter int  N     = 4,
   parameter int  MODE  = MODE_SEL,
   localparam int SEL_W = clog2_min1(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SEL_W-1:0]   sel,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_sel,
   output logic               out_valid,
   input  logic               out_ready
`ifdef MUX_PIPE_SELERR_EN
   ,
   output logic               sel_err
`endif
);

   logic             w_accept;
   logic             w_grant_valid;
   logic [SEL_W-1:0] w_grant_idx;
   logic             w_transfer;
   logic [WIDTH-1:0] w_mux_data;

   logic [WIDTH-1:0] r_out_data;
   logic [SEL_W-1:0] r_out_sel;
   logic             r_out_valid;

   // The stage can take a word whenever it is empty or its word leaves this cycle.
   assign w_accept   = !r_out_valid || out_ready;
   assign w_transfer = w_accept && w_grant_valid;

   generate
      if (MODE == MODE_RR) begin : g_rr
         logic [SEL_W-1:0] r_rr_ptr;

         rr_arbiter_n #(
            .N (N)
         ) u_arb (
            .req       (in_valid),
            .ptr       (r_rr_ptr),
            .gnt_idx   (w_grant_idx),
            .gnt_valid (w_grant_valid)
         );

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_rr_ptr <= '0;
            end else if (w_transfer) begin
               r_rr_ptr <= (w_grant_idx == SEL_W'(N - 1)) ? '0 : w_grant_idx + SEL_W'(1);
            end
         end
      end else begin : g_sel
         logic [N-1:0] w_sel_match;

         // An out-of-range sel matches no channel, so it can never grant.
         for (genvar gi = 0; gi < N; gi++) begin : g_match
            assign w_sel_match[gi] = (sel == SEL_W'(gi));
         end

         assign w_grant_idx   = sel;
         assign w_grant_valid = |(w_sel_match & in_valid);
      end
   endgenerate

   for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign in_ready[gi] = w_transfer && (w_grant_idx == SEL_W'(gi));
   end

   always_comb begin
      w_mux_data = '0;
      for (int i = 0; i < N; i++) begin
         if (w_grant_idx == SEL_W'(i)) begin
            w_mux_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // A load wins over a drain, so back-to-back words keep out_valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_sel   <= '0;
         r_out_valid <= 1'b0;
      end else if (w_transfer) begin
         r_out_data  <= w_mux_data;
         r_out_sel   <= w_grant_idx;
         r_out_valid <= 1'b1;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;
   assign out_valid = r_out_valid;

`ifdef MUX_PIPE_SELERR_EN
   logic w_sel_oor;
   logic r_sel_err;

   assign w_sel_oor = ({1'b0, sel} >= (SEL_W+1)'(N));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel_err <= 1'b0;
      end else if ((MODE == MODE_SEL) && w_sel_oor && (|in_valid)) begin
         r_sel_err <= 1'b1;
      end
   end

   assign sel_err = r_sel_err;
`endif

endmodule

// File: tb/tb_mux_pipe_n.sv
// Bench for mux_pipe_n: three instances (N=4 select, N=3 select, N=4 round-robin)
// checked against a cycle-level reference model kept in the bench.
module tb_mux_pipe_n;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Stimulus storage; index k selects the instance, second index the channel.
   logic [31:0]  bd [3][4];
   logic [3:0]   bv [3];
   logic [1:0]   bs [3];
   logic [2:0]   ordy;

   logic [127:0] d0, d2;
   logic [95:0]  d1;
   logic [3:0]   rdy0, rdy2;
   logic [2:0]   rdy1;
   logic [31:0]  od [3];
   logic [1:0]   os [3];
   logic [2:0]   ov;
`ifdef MUX_PIPE_SELERR_EN
   logic [2:0]   err;
`endif

   assign d0 = {bd[0][3], bd[0][2], bd[0][1], bd[0][0]};
   assign d1 = {bd[1][2], bd[1][1], bd[1][0]};
   assign d2 = {bd[2][3], bd[2][2], bd[2][1], bd[2][0]};

   mux_pipe_n #(.WIDTH(32), .N(4), .MODE(0)) u_sel4 (
      .clk(clk), .rst_n(rst_n), .in_data(d0), .in_valid(bv[0]), .in_ready(rdy0),
      .sel(bs[0]), .out_data(od[0]), .out_sel(os[0]), .out_valid(ov[0]), .out_ready(ordy[0])
`ifdef MUX_PIPE_SELERR_EN
      , .sel_err(err[0])
`endif
   );

   mux_pipe_n #(.WIDTH(32), .N(3), .MODE(0)) u_sel3 (
      .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(bv[1][2:0]), .in_ready(rdy1),
      .sel(bs[1]), .out_data(od[1]), .out_sel(os[1]), .out_valid(ov[1]), .out_ready(ordy[1])
`ifdef MUX_PIPE_SELERR_EN
      , .sel_err(err[1])
`endif
   );

   mux_pipe_n #(.WIDTH(32), .N(4), .MODE(1)) u_rr4 (
      .clk(clk), .rst_n(rst_n), .in_data(d2), .in_valid(bv[2]), .in_ready(rdy2),
      .sel(bs[2]), .out_data(od[2]), .out_sel(os[2]), .out_valid(ov[2]), .out_ready(ordy[2])
`ifdef MUX_PIPE_SELERR_EN
      , .sel_err(err[2])
`endif
   );

   // Reference model state
   int          mn [3] = '{4, 3, 4};
   int          mm [3] = '{0, 0, 1};
   logic        m_valid [3];
   logic [31:0] m_data [3];
   int          m_sel [3];
   int          m_ptr [3];
   logic        m_err [3];
   logic [3:0]  e_rdy [3];
   logic [3:0]  a_rdy [3];

   int checks = 0;
   int errors = 0;

   function automatic logic [3:0] chan_mask(input int k);
      return 4'((1 << mn[k]) - 1);
   endfunction

   // Grant rule straight from the behaviour description.
   function automatic void model_grant(input int k, output bit gv, output int g);
      int         c;
      logic [3:0] v;
      v  = bv[k] & chan_mask(k);
      gv = 1'b0;
      g  = 0;
      if (mm[k] == 0) begin
         if (int'(bs[k]) < mn[k] && v[bs[k]]) begin
            gv = 1'b1;
            g  = int'(bs[k]);
         end
      end else begin
         for (int j = 0; j < mn[k]; j++) begin
            c = (m_ptr[k] + j) % mn[k];
            if (!gv && v[c]) begin
               gv = 1'b1;
               g  = c;
            end
         end
      end
   endfunction

   task automatic clear_models();
      for (int k = 0; k < 3; k++) begin
         m_valid[k] = 1'b0;
         m_data[k]  = 32'h0;
         m_sel[k]   = 0;
         m_ptr[k]   = 0;
         m_err[k]   = 1'b0;
      end
   endtask

   task automatic set_idle();
      for (int k = 0; k < 3; k++) begin
         bv[k] = 4'h0;
         bs[k] = 2'd0;
         for (int c = 0; c < 4; c++) bd[k][c] = 32'h0;
      end
      ordy = 3'b111;
   endtask

   task automatic rand_drive(input int k);
      bv[k]   = 4'($urandom);
      bs[k]   = 2'($urandom);
      for (int c = 0; c < 4; c++) bd[k][c] = $urandom;
      ordy[k] = ($urandom_range(0, 3) != 0);
   endtask

   // One clock: sample ready before the edge, advance the model on the edge.
   task automatic tick();
      bit   gv;
      int   g;
      logic acc;
      #1;
      for (int k = 0; k < 3; k++) begin
         model_grant(k, gv, g);
         acc      = !m_valid[k] || ordy[k];
         e_rdy[k] = (acc && gv) ? 4'(1 << g) : 4'b0;
      end
      a_rdy[0] = rdy0;
      a_rdy[1] = {1'b0, rdy1};
      a_rdy[2] = rdy2;
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         model_grant(k, gv, g);
         acc = !m_valid[k] || ordy[k];
         if (mm[k] == 0 && int'(bs[k]) >= mn[k] && (bv[k] & chan_mask(k)) != 4'h0)
            m_err[k] = 1'b1;
         if (acc && gv) begin
            m_valid[k] = 1'b1;
            m_data[k]  = bd[k][g];
            m_sel[k]   = g;
            if (mm[k] == 1) m_ptr[k] = (g + 1) % mn[k];
         end else if (ordy[k]) begin
            m_valid[k] = 1'b0;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      set_idle();
      clear_models();
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_models();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) rand_drive(k);
         @(posedge clk);
         #1;
         for (int k = 0; k < 3; k++) begin
            if (ov[k] !== 1'b0 || od[k] !== 32'h0 || os[k] !== 2'd0) begin
               errors++;
               $display("FAIL reset_hold k=%0d got v=%b d=%h s=%0d want v=0 d=0 s=0", k, ov[k], od[k], os[k]);
            end
            checks++;
         end
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) bv[k] = 4'hF;
      ordy = 3'b111;
      #2 rst_n = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         if (ov[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset_release k=%0d got out_valid=%b want 0", k, ov[k]);
         end
         checks++;
      end
      tick();
      for (int k = 0; k < 3; k++) begin
         if (ov[k] !== m_valid[k] || od[k] !== m_data[k] || os[k] !== 2'(m_sel[k])) begin
            errors++;
            $display("FAIL reset_first k=%0d got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                     k, ov[k], od[k], os[k], m_valid[k], m_data[k], m_sel[k]);
         end
         checks++;
      end
   endtask

   task automatic test_mode0_sweep();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         for (int c = 0; c < 4; c++) bd[0][c] = 32'(c + 1);
         bv[0]   = 4'hF;
         ordy[0] = 1'b1;
         bs[0]   = 2'(i);
         tick();
         if (a_rdy[0] !== e_rdy[0]) begin
            errors++;
            $display("FAIL sweep_ready sel=%0d got %b want %b", i, a_rdy[0], e_rdy[0]);
         end
         checks++;
         if (ov[0] !== 1'b1 || od[0] !== 32'(i + 1) || os[0] !== 2'(i)) begin
            errors++;
            $display("FAIL sweep_out sel=%0d got v=%b d=%h s=%0d want v=1 d=%h s=%0d",
                     i, ov[0], od[0], os[0], 32'(i + 1), i);
         end
         checks++;
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      @(negedge clk);
      bv[0] = 4'hF; bs[0] = 2'd2; bd[0][2] = 32'hA5A5A5A5; ordy[0] = 1'b1;
      tick();
      if (ov[0] !== 1'b1 || od[0] !== 32'hA5A5A5A5 || os[0] !== 2'd2) begin
         errors++;
         $display("FAIL bp_load got v=%b d=%h s=%0d want v=1 d=a5a5a5a5 s=2", ov[0], od[0], os[0]);
      end
      checks++;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         ordy[0] = 1'b0; bd[0][2] = 32'hDEADBEEF;
         tick();
         if (a_rdy[0] !== 4'b0000 || ov[0] !== 1'b1 || od[0] !== 32'hA5A5A5A5 || os[0] !== 2'd2) begin
            errors++;
            $display("FAIL bp_stall cyc=%0d got rdy=%b v=%b d=%h s=%0d want rdy=0000 v=1 d=a5a5a5a5 s=2",
                     c, a_rdy[0], ov[0], od[0], os[0]);
         end
         checks++;
      end
      @(negedge clk);
      ordy[0] = 1'b1;
      tick();
      if (a_rdy[0] !== 4'b0100 || ov[0] !== 1'b1 || od[0] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL bp_release got rdy=%b v=%b d=%h want rdy=0100 v=1 d=deadbeef", a_rdy[0], ov[0], od[0]);
      end
      checks++;
   endtask

   task automatic test_out_of_range();
      do_reset();
      @(negedge clk);
      bv[1] = 4'h7; bs[1] = 2'd0; bd[1][0] = 32'h11110000; ordy[1] = 1'b1;
      tick();
      @(negedge clk);
      bs[1] = 2'd3;
      tick();
      if (a_rdy[1] !== 4'b0000 || ov[1] !== 1'b0) begin
         errors++;
         $display("FAIL oor_block got rdy=%b v=%b want rdy=000 v=0", a_rdy[1][2:0], ov[1]);
      end
      checks++;
`ifdef MUX_PIPE_SELERR_EN
      if (err[1] !== 1'b1) begin
         errors++;
         $display("FAIL oor_selerr_set got %b want 1", err[1]);
      end
      checks++;
`endif
      @(negedge clk);
      bs[1] = 2'd0;
      tick();
      if (ov[1] !== 1'b1 || od[1] !== 32'h11110000 || os[1] !== 2'd0) begin
         errors++;
         $display("FAIL oor_recover got v=%b d=%h s=%0d want v=1 d=11110000 s=0", ov[1], od[1], os[1]);
      end
      checks++;
`ifdef MUX_PIPE_SELERR_EN
      if (err[1] !== 1'b1) begin
         errors++;
         $display("FAIL oor_selerr_sticky got %b want 1", err[1]);
      end
      checks++;
`endif
   endtask

   task automatic test_round_robin();
      int exp_seq [9] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         bv[2]   = (i < 5) ? 4'b1111 : 4'b1010;
         bs[2]   = 2'($urandom);
         ordy[2] = 1'b1;
         for (int c = 0; c < 4; c++) bd[2][c] = $urandom;
         tick();
         if (ov[2] !== 1'b1 || os[2] !== 2'(exp_seq[i]) || od[2] !== m_data[2]) begin
            errors++;
            $display("FAIL rr_seq step=%0d got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                     i, ov[2], os[2], od[2], exp_seq[i], m_data[2]);
         end
         checks++;
      end
   endtask

   task automatic test_reset_mid_stall();
      logic [3:0] v;
      int         lowest;
      do_reset();
      @(negedge clk);
      bv[2] = 4'hF; ordy[2] = 1'b1; bd[2][0] = 32'h0BADF00D;
      tick();
      @(negedge clk);
      ordy[2] = 1'b0;
      tick();
      if (ov[2] !== 1'b1 || a_rdy[2] !== 4'b0000) begin
         errors++;
         $display("FAIL stall_setup got v=%b rdy=%b want v=1 rdy=0000", ov[2], a_rdy[2]);
      end
      checks++;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      if (ov[2] !== 1'b0 || od[2] !== 32'h0 || os[2] !== 2'd0) begin
         errors++;
         $display("FAIL async_reset got v=%b d=%h s=%0d want v=0 d=0 s=0", ov[2], od[2], os[2]);
      end
      checks++;
      set_idle();
      clear_models();
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      v = 4'($urandom_range(1, 15));
      lowest = 0;
      while (!v[lowest]) lowest++;
      bv[2] = v; ordy[2] = 1'b1;
      for (int c = 0; c < 4; c++) bd[2][c] = $urandom;
      tick();
      if (ov[2] !== 1'b1 || os[2] !== 2'(lowest) || od[2] !== bd[2][lowest]) begin
         errors++;
         $display("FAIL post_reset_grant valid=%b got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                  v, ov[2], os[2], od[2], lowest, bd[2][lowest]);
      end
      checks++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) rand_drive(k);
         tick();
         for (int k = 0; k < 3; k++) begin
            if (a_rdy[k] !== e_rdy[k]) begin
               errors++;
               $display("FAIL rand_ready cyc=%0d k=%0d got %b want %b", i, k, a_rdy[k], e_rdy[k]);
            end
            checks++;
            if (ov[k] !== m_valid[k] || od[k] !== m_data[k] || os[k] !== 2'(m_sel[k])) begin
               errors++;
               $display("FAIL rand_out cyc=%0d k=%0d got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                        i, k, ov[k], od[k], os[k], m_valid[k], m_data[k], m_sel[k]);
            end
            checks++;
`ifdef MUX_PIPE_SELERR_EN
            if (err[k] !== m_err[k]) begin
               errors++;
               $display("FAIL rand_selerr cyc=%0d k=%0d got %b want %b", i, k, err[k], m_err[k]);
            end
            checks++;
`endif
         end
      end
   endtask

   initial begin
      set_idle();
      test_reset();
      test_mode0_sweep();
      test_backpressure();
      test_out_of_range();
      test_round_robin();
      test_reset_mid_stall();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
